// File: rtl/vcpu_ctrl_pkg.sv
// rtl/vcpu_ctrl_pkg.sv - shared state type and default sizes for the vector CPU control path
package vcpu_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOST_WAIT,
      START,
      RUN,
      DRAIN
   } ctrl_state_t;

   localparam int DEF_I            = 32;
   localparam int DEF_N            = 8;
   localparam int DEF_R            = 6;
   localparam int DEF_DRAIN_CYCLES = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating counter: counts up to LIMIT, or loads LIMIT and counts down to 0
module sat_counter #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] LIMIT = '1,
   parameter bit               DOWN  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic             enable,
   output logic [WIDTH-1:0] value,
   output logic             terminal
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (load) begin
         value <= LIMIT;
      end else if (enable) begin
         if (DOWN) begin
            if (value != '0) value <= value - WIDTH'(1);
         end else begin
            if (value != LIMIT) value <= value + WIDTH'(1);
         end
      end
   end

   // Up mode flags the last step before the limit so the owner can act in that same cycle.
   assign terminal = DOWN ? (value == '0) : (value == LIMIT - WIDTH'(1));

endmodule

// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - run sequencer and data-memory port owner between host loader and vector CPU
module mem_access_controller
   import vcpu_ctrl_pkg::*;
#(
   parameter int          I            = DEF_I,
   parameter int          N            = DEF_N,
   parameter int          R            = DEF_R,
   parameter int          DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int unsigned MAX_CYCLES   = 32'd1_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                host_req,
   input  logic                host_we,
   input  logic [I-1:0]        host_addr,
   input  logic [R-1:0][N-1:0] host_wdata,
   output logic                host_ack,
   output logic [R-1:0][N-1:0] host_rdata,
   input  logic                run,
   output logic                busy,
   output logic                done,
   output logic                timeout,
   output logic [31:0]         run_cycles,
   output logic                cpu_start,
   input  logic                cpu_end,
   input  logic [I-1:0]        cpu_addr,
   input  logic                cpu_we,
   input  logic [R-1:0][N-1:0] cpu_wdata,
   output logic [R-1:0][N-1:0] cpu_rdata,
   output logic [I-1:0]        mem_addr,
   output logic                mem_we,
   output logic [R-1:0][N-1:0] mem_wdata,
   input  logic [R-1:0][N-1:0] mem_rdata
);

   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   ctrl_state_t   state;
   logic          runTerm;
   logic          drainTerm;
   logic [DW-1:0] unusedDrainCount;

   sat_counter #(
      .WIDTH (32),
      .LIMIT (32'(MAX_CYCLES)),
      .DOWN  (1'b0)
   ) runCounter (
      .clk      (clk),
      .rst_n    (reset),
      .clear    (state == START),
      .load     (1'b0),
      .enable   (state == RUN),
      .value    (run_cycles),
      .terminal (runTerm)
   );

   sat_counter #(
      .WIDTH (DW),
      .LIMIT (DW'(DRAIN_CYCLES - 1)),
      .DOWN  (1'b1)
   ) drainCounter (
      .clk      (clk),
      .rst_n    (reset),
      .clear    (1'b0),
      .load     (state == RUN && cpu_end),
      .enable   (state == DRAIN),
      .value    (unusedDrainCount),
      .terminal (drainTerm)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         done    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (host_req)  state <= HOST_WAIT;
               else if (run)  state <= START;
            end
            HOST_WAIT: state <= IDLE;
            START: begin
               done    <= 1'b0;
               timeout <= 1'b0;
               state   <= RUN;
            end
            RUN: begin
               // End of program beats the watchdog when both land in the same cycle.
               if (cpu_end) begin
                  state <= DRAIN;
               end else if (runTerm) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  state   <= IDLE;
               end
            end
            DRAIN: begin
               if (drainTerm) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = 1'b0;
      case (state)
         IDLE: mem_we = host_req & host_we;
         RUN, DRAIN: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
         end
         default: mem_we = 1'b0;
      endcase
   end

   assign host_ack   = (state == HOST_WAIT);
   assign host_rdata = host_ack ? mem_rdata : '0;
   assign cpu_start  = (state == START);
   assign busy       = (state == START) || (state == RUN) || (state == DRAIN);
   assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_access_controller.sv
// tb/tb_mem_access_controller.sv - directed self-checking bench for mem_access_controller
module tb_mem_access_controller;

   localparam int I = 32;
   localparam int N = 8;
   localparam int R = 6;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                host_req = 1'b0;
   logic                host_we = 1'b0;
   logic [I-1:0]        host_addr = '0;
   logic [R-1:0][N-1:0] host_wdata = '0;
   logic                host_ack;
   logic [R-1:0][N-1:0] host_rdata;
   logic                run = 1'b0;
   logic                busy;
   logic                done;
   logic                timeout;
   logic [31:0]         run_cycles;
   logic                cpu_start;
   logic                cpu_end = 1'b0;
   logic [I-1:0]        cpu_addr = '0;
   logic                cpu_we = 1'b0;
   logic [R-1:0][N-1:0] cpu_wdata = '0;
   logic [R-1:0][N-1:0] cpu_rdata;
   logic [I-1:0]        mem_addr;
   logic                mem_we;
   logic [R-1:0][N-1:0] mem_wdata;
   logic [R-1:0][N-1:0] mem_rdata = '0;

   logic [47:0] memArray [0:63];
   int weCount = 0;
   int startCount = 0;
   int nChecks = 0;
   int nErrors = 0;
   int snapWe;
   int snapStart;

   mem_access_controller #(
      .I            (I),
      .N            (N),
      .R            (R),
      .DRAIN_CYCLES (4),
      .MAX_CYCLES   (50)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .run        (run),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .run_cycles (run_cycles),
      .cpu_start  (cpu_start),
      .cpu_end    (cpu_end),
      .cpu_addr   (cpu_addr),
      .cpu_we     (cpu_we),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port memory with one-cycle synchronous read.
   always @(posedge clk) begin
      if (mem_we) memArray[mem_addr[5:0]] <= mem_wdata;
      mem_rdata <= memArray[mem_addr[5:0]];
   end

   always @(posedge clk) begin
      if (mem_we)    weCount    <= weCount + 1;
      if (cpu_start) startCount <= startCount + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      host_addr = 32'd7;
      host_wdata = 48'h123456789ABC;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_run_cycles", run_cycles, 0);
      check("rst_ack", host_ack, 0);
      check("rst_cpu_start", cpu_start, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 7);
      check("rst_mem_wdata", mem_wdata, 48'h123456789ABC);
      cyc();
      cyc();
      reset = 1'b1;

      // Host write then read back.
      snapWe = weCount;
      cyc();
      host_req = 1'b1; host_we = 1'b1; host_addr = 32'd5; host_wdata = 48'h0A0B0C0D0E0F;
      #2;
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_addr", mem_addr, 5);
      check("wr_ack_early", host_ack, 0);
      cyc();
      host_req = 1'b0;
      #2;
      check("wr_ack", host_ack, 1);
      check("wr_ack_mem_we", mem_we, 0);
      cyc();
      host_req = 1'b1; host_we = 1'b0;
      #2;
      check("rd_mem_we", mem_we, 0);
      check("rd_ack_early", host_ack, 0);
      cyc();
      host_req = 1'b0;
      #2;
      check("rd_ack", host_ack, 1);
      check("rd_data", host_rdata, 48'h0A0B0C0D0E0F);
      check("cpu_rdata", cpu_rdata, 48'h0A0B0C0D0E0F);
      check("wr_we_pulses", weCount - snapWe, 1);

      // Normal run: cpu_end on 10th RUN cycle, host read pending during RUN, store in 2nd DRAIN cycle.
      snapStart = startCount;
      cyc();
      run = 1'b1;
      #2;
      check("run_idle_busy", busy, 0);
      cyc();
      run = 1'b0;
      #2;
      check("start_pulse", cpu_start, 1);
      check("start_busy", busy, 1);
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (i == 3) begin
            host_req = 1'b1; host_we = 1'b0; host_addr = 32'd5;
         end
         if (i == 10) cpu_end = 1'b1;
         #2;
         check("run_count", run_cycles, i - 1);
         check("run_no_ack", host_ack, 0);
         if (i == 1) check("run_start_low", cpu_start, 0);
      end
      cyc();
      cpu_end = 1'b0;
      #2;
      check("drain1_count", run_cycles, 10);
      check("drain1_done", done, 0);
      cyc();
      cpu_we = 1'b1; cpu_addr = 32'd9; cpu_wdata = 48'h112233445566;
      #2;
      check("drain2_mem_we", mem_we, 1);
      check("drain2_mem_addr", mem_addr, 9);
      cyc();
      cpu_we = 1'b0;
      #2;
      check("drain3_done", done, 0);
      cyc();
      #2;
      check("drain4_done", done, 0);
      check("drain4_busy", busy, 1);
      check("drain4_no_ack", host_ack, 0);
      cyc();
      #2;
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_timeout", timeout, 0);
      check("end_count", run_cycles, 10);
      check("end_ack_pending", host_ack, 0);
      cyc();
      host_req = 1'b0;
      #2;
      check("post_run_ack", host_ack, 1);
      check("post_run_rdata", host_rdata, 48'h0A0B0C0D0E0F);
      check("run_start_pulses", startCount - snapStart, 1);
      cyc();
      host_req = 1'b1; host_addr = 32'd9;
      cyc();
      host_req = 1'b0;
      #2;
      check("drain_store_rdata", host_rdata, 48'h112233445566);

      // host_req and run together: host first, then start; this run times out.
      cyc();
      host_req = 1'b1; host_addr = 32'd5; run = 1'b1;
      #2;
      check("both_no_start", cpu_start, 0);
      cyc();
      host_req = 1'b0;
      #2;
      check("both_ack", host_ack, 1);
      check("both_wait_start", cpu_start, 0);
      cyc();
      #2;
      check("both_idle_start", cpu_start, 0);
      check("both_idle_busy", busy, 0);
      cyc();
      run = 1'b0;
      #2;
      check("both_start", cpu_start, 1);
      for (int i = 1; i <= 50; i++) begin
         cyc();
         #2;
         if (i == 1) check("wd_done_cleared", done, 0);
         if (i == 50) begin
            check("wd_last_count", run_cycles, 49);
            check("wd_last_busy", busy, 1);
         end
      end
      snapWe = weCount;
      cyc();
      cpu_we = 1'b1; cpu_addr = 32'd9; cpu_wdata = 48'hFFFFFFFFFFFF;
      #2;
      check("wd_timeout", timeout, 1);
      check("wd_done", done, 1);
      check("wd_busy", busy, 0);
      check("wd_count", run_cycles, 50);
      check("wd_blocked_we", mem_we, 0);
      cyc();
      #2;
      check("wd_blocked_we2", mem_we, 0);
      cyc();
      cpu_we = 1'b0;
      #2;
      check("wd_we_pulses", weCount - snapWe, 0);
      check("wd_timeout_sticky", timeout, 1);

      // Asynchronous reset mid-RUN, then a fresh run ending in its first RUN cycle.
      cyc();
      run = 1'b1;
      cyc();
      run = 1'b0;
      cyc();
      cyc();
      cyc();
      #2;
      check("pre_rst_count", run_cycles, 2);
      reset = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_done", done, 0);
      check("async_count", run_cycles, 0);
      check("async_timeout", timeout, 0);
      cyc();
      reset = 1'b1;
      cyc();
      run = 1'b1;
      cyc();
      run = 1'b0;
      #2;
      check("rerun_start", cpu_start, 1);
      cyc();
      cpu_end = 1'b1;
      #2;
      check("rerun_first_count", run_cycles, 0);
      cyc();
      cpu_end = 1'b0;
      #2;
      check("rerun_count", run_cycles, 1);
      cyc();
      cyc();
      cyc();
      #2;
      check("rerun_drain_done", done, 0);
      cyc();
      #2;
      check("rerun_done", done, 1);
      check("rerun_busy", busy, 0);
      check("rerun_final_count", run_cycles, 1);
      check("rerun_timeout", timeout, 0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
